hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side counterpart to the pipeline forwarding logic. Tracks in-flight long-latency register writes (loads) in a 32-entry scoreboard.
- Detects hazards that forwarding cannot cover and drives stall, bubble and flush controls into the IF and ID stages.
- Sits beside the decode stage. Monitors the ID instruction, the ID/EX register and load write-back completions.

Parameters:
- MAX_OUTSTANDING, 4, maximum loads in flight; counter width is $clog2(MAX_OUTSTANDING+1).
- STALL_TIMEOUT, 64, consecutive stall cycles before the sticky watchdog error sets.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  valid instruction in IF/ID.
- id_rs1  in  5  source register 1 of the ID instruction.
- id_rs2  in  5  source register 2 of the ID instruction.
- id_uses_rs2  in  1  rs2 is actually read.
- id_rd  in  5  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a long-latency load.
- id_is_branch  in  1  ID instruction resolves a branch in ID.
- ex_rd  in  5  ID/EX destination register.
- ex_reg_write  in  1  ID/EX RegWrite.
- wb_valid  in  1  a load completes write-back this cycle.
- wb_rd  in  5  destination register of the completing load.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_ex_bubble  out  1  zero the control fields entering ID/EX.
- if_id_flush  out  1  clear IF/ID.
- stall_cause  out  3  0 none, 1 RAW_SB, 2 WAW, 3 FULL, 4 BR_EX.
- pending  out  32  scoreboard bitmap.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  loads in flight.
- wd_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_n low):
  - pending=0, outstanding=0, stall counter=0, wd_err=0.
  - All control outputs and stall_cause are forced to 0 while rst_n is low.
- Clear mask: clr = wb_valid && wb_rd!=0 ? onehot(wb_rd) : 0.
- Effective pending: eff = pending & ~clr. All hazard checks use eff, so a completion bypasses into the same cycle.
- Hazards are combinational and evaluated only when id_valid=1. Priority order:
  1. RAW_SB: (rs1!=0 && eff[rs1]) || (id_uses_rs2 && rs2!=0 && eff[rs2]).
  2. WAW: id_is_load && id_reg_write && id_rd!=0 && eff[id_rd].
  3. FULL: id_is_load && outstanding_eff==MAX_OUTSTANDING, where outstanding_eff = outstanding - (clr!=0).
  4. BR_EX: id_is_branch && ex_reg_write && ex_rd!=0 && ex_rd matches rs1 (or rs2 when used). Single-cycle ALU result; the next cycle it is forwarded from EX/MEM.
- Any hazard: pc_stall=if_id_stall=id_ex_bubble=1, and stall_cause takes the highest-priority code.
- Flush: if_id_flush = branch_taken && !hazard. A stall suppresses the flush; the branch re-resolves once the stall ends.
- Issue: issue = id_valid && !hazard && id_is_load && id_reg_write && id_rd!=0.
- Scoreboard update at posedge:
  - pending <= (pending & ~clr) | (issue ? onehot(id_rd) : 0).
  - Set wins over clear for the same register.
  - outstanding <= outstanding + issue - (clr!=0). Issue and completion in the same cycle leave the count unchanged.
  - Load to x0 is never tracked.
- Fault cases (must not wrap):
  - wb_valid to a non-pending register: no state change except that bit's clear.
  - Counter decrement when outstanding=0 saturates at 0.
- Watchdog:
  - Counter increments on each stalled cycle and resets to 0 on any non-stall cycle.
  - When the counter reaches STALL_TIMEOUT-1 while stalled, wd_err <= 1. It stays set until reset.
- Latency: hazard-to-stall is 0 cycles (combinational). Issue-to-pending visibility is 1 cycle; the bypass covers completion.

Decomposition:
- Shared package (hazard_pkg):
  - NUM_REGS=32 and REG_IDX_W=5.
  - stall_cause_t enum (NONE, RAW_SB, WAW, FULL, BR_EX).
- Sub-module reg_scoreboard: pending bitmap, clear/set logic, outstanding counter, eff output.
- Top level: hazard priority, output drive and watchdog.

Test Plan:
- Load x5 issues, next cycle ID reads rs1=5 -> stall_cause=1 and all stalls=1 until wb_valid,wb_rd=5. In that wb cycle stall=0 (bypass), and pending[5] reads 0 the following cycle.
- Load x7 pending, second load to x7 in ID -> stall_cause=2. The second load issues in the wb_rd=7 cycle, and pending[7] stays 1.
- Four loads to x1..x4 with no completions, fifth load -> stall_cause=3 with outstanding=4. A completion the same cycle as the fifth load lets it issue, and outstanding stays 4.
- ex_rd=9, ex_reg_write=1, branch in ID with rs2=9, id_uses_rs2=1, branch_taken=1 -> 1-cycle stall, stall_cause=4, if_id_flush=0. Next cycle flush=1 and stall=0.
- Load to x0, then rs1=0 reader -> pending stays 0, outstanding stays 0, no stall.
- Hold RAW_SB stall for 64 cycles -> wd_err=1 at cycle 64. Assert rst_n=0 mid-stall -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard / stall logic.
package hazard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        RAW_SB = 3'd1,
        WAW    = 3'd2,
        FULL   = 3'd3,
        BR_EX  = 3'd4
    } stall_cause_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load bitmap and outstanding-load counter, with same-cycle completion bypass on eff.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]  pending,
    output logic [NUM_REGS-1:0]  eff,
    output logic [CNT_W-1:0]     outstanding,
    output logic [CNT_W-1:0]     outstanding_eff
);

    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] set;
    logic                dec;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        clr = '0;
        set = '0;
        if (wb_valid && wb_rd != '0)
            clr = onehot(wb_rd);
        if (issue && issue_rd != '0)
            set = onehot(issue_rd);
    end

    // A completion for a register that was never pending only clears its bit;
    // it must not pull the count down.
    assign eff             = pending & ~clr;
    assign dec             = |(pending & clr);
    assign outstanding_eff = (dec && outstanding != '0) ? outstanding - CNT_W'(1) : outstanding;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending     <= eff | set;
            outstanding <= outstanding_eff + CNT_W'(issue);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-side hazard detector: prioritises scoreboard and branch hazards, drives
// IF/ID stall, bubble and flush controls, and runs a stall watchdog.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_TIMEOUT   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   id_valid,
    input  logic [4:0]                             id_rs1,
    input  logic [4:0]                             id_rs2,
    input  logic                                   id_uses_rs2,
    input  logic [4:0]                             id_rd,
    input  logic                                   id_reg_write,
    input  logic                                   id_is_load,
    input  logic                                   id_is_branch,
    input  logic [4:0]                             ex_rd,
    input  logic                                   ex_reg_write,
    input  logic                                   wb_valid,
    input  logic [4:0]                             wb_rd,
    input  logic                                   branch_taken,
    output logic                                   pc_stall,
    output logic                                   if_id_stall,
    output logic                                   id_ex_bubble,
    output logic                                   if_id_flush,
    output logic [2:0]                             stall_cause,
    output logic [31:0]                            pending,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   wd_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

    logic [NUM_REGS-1:0] eff;
    logic [CNT_W-1:0]    outstanding_eff;
    stall_cause_t        cause;
    logic                hazard;
    logic                issue;
    logic                raw, waw, full, br_ex;
    logic [WD_W-1:0]     wd_cnt;

    reg_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_sb (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .issue           (issue),
        .issue_rd        (id_rd),
        .pending         (pending),
        .eff             (eff),
        .outstanding     (outstanding),
        .outstanding_eff (outstanding_eff)
    );

    always_comb begin
        raw   = (id_rs1 != '0 && eff[id_rs1]) ||
                (id_uses_rs2 && id_rs2 != '0 && eff[id_rs2]);
        waw   = id_is_load && id_reg_write && id_rd != '0 && eff[id_rd];
        full  = id_is_load && outstanding_eff == CNT_W'(MAX_OUTSTANDING);
        // ALU result in EX is not forwardable to the ID branch comparator until next cycle.
        br_ex = id_is_branch && ex_reg_write && ex_rd != '0 &&
                (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));

        cause = NONE;
        if (id_valid) begin
            if (raw)        cause = RAW_SB;
            else if (waw)   cause = WAW;
            else if (full)  cause = FULL;
            else if (br_ex) cause = BR_EX;
        end
    end

    assign hazard = (cause != NONE);
    assign issue  = id_valid && !hazard && id_is_load && id_reg_write && id_rd != '0;

    // Controls are gated by rst_n so they drop the instant reset asserts.
    assign pc_stall     = rst_n && hazard;
    assign if_id_stall  = rst_n && hazard;
    assign id_ex_bubble = rst_n && hazard;
    assign if_id_flush  = rst_n && branch_taken && !hazard;
    assign stall_cause  = rst_n ? cause : NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (hazard) begin
            if (wd_cnt == WD_LAST)
                wd_err <= 1'b1;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: per-cycle vector table with an expected-result queue,
// plus hand-written watchdog and asynchronous-reset sequences.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs2, id_reg_write, id_is_load, id_is_branch;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
    logic        ex_reg_write, wb_valid, branch_taken;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, wd_err;
    logic [2:0]  stall_cause;
    logic [31:0] pending;
    logic [2:0]  outstanding;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MAX_OUTSTANDING(4), .STALL_TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .branch_taken (branch_taken),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .stall_cause  (stall_cause),
        .pending      (pending),
        .outstanding  (outstanding),
        .wd_err       (wd_err)
    );

    typedef struct packed {
        logic        stall;
        logic [2:0]  cause;
        logic        flush;
        logic [31:0] pend;
        logic [2:0]  outs;
    } exp_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        logic [4:0] exrd;
        logic       exrw;
        logic       wbv;
        logic [4:0] wbrd;
        logic       bt;
        exp_t       exp;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(
        input logic valid, input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd, input logic rw, input logic ld, input logic br,
        input logic [4:0] exrd, input logic exrw, input logic wbv, input logic [4:0] wbrd,
        input logic bt, input logic stall, input logic [2:0] cause, input logic flush,
        input logic [31:0] pend, input logic [2:0] outs);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.rw = rw;
        v.ld = ld; v.br = br; v.exrd = exrd; v.exrw = exrw; v.wbv = wbv; v.wbrd = wbrd;
        v.bt = bt;
        v.exp.stall = stall; v.exp.cause = cause; v.exp.flush = flush;
        v.exp.pend = pend; v.exp.outs = outs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_is_load = 0; id_is_branch = 0; ex_rd = 0;
        ex_reg_write = 0; wb_valid = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.u2;
        id_rd = v.rd; id_reg_write = v.rw; id_is_load = v.ld; id_is_branch = v.br;
        ex_rd = v.exrd; ex_reg_write = v.exrw; wb_valid = v.wbv; wb_rd = v.wbrd;
        branch_taken = v.bt;
        exp_q.push_back(v.exp);
    endtask

    task automatic compare(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("v%0d_queue_empty", idx), 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d_stalls", idx), {29'd0, pc_stall, if_id_stall, id_ex_bubble}, {29'd0, {3{e.stall}}});
        check($sformatf("v%0d_cause", idx), {29'd0, stall_cause}, {29'd0, e.cause});
        check($sformatf("v%0d_flush", idx), {31'd0, if_id_flush}, {31'd0, e.flush});
        check($sformatf("v%0d_pending", idx), pending, e.pend);
        check($sformatf("v%0d_outstanding", idx), {29'd0, outstanding}, {29'd0, e.outs});
    endtask

    initial begin
        //          vld rs1 rs2 u2 rd rw ld br exrd exrw wbv wbrd bt  stl cau fl pend          outs
        // RAW on a pending load, released by same-cycle completion bypass
        tbl.push_back(mk(1,  0,  0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1,  5,  0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h20,       1));
        tbl.push_back(mk(1,  5,  0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h20,       1));
        tbl.push_back(mk(1,  5,  0, 0, 6, 1, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 32'h20,       1));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        // WAW, second load issues alongside completion; set wins over clear
        tbl.push_back(mk(1,  0,  0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1,  0,  0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0,  1, 2, 0, 32'h80,       1));
        tbl.push_back(mk(1,  0,  0, 0, 7, 1, 1, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h80,       1));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h80,       1));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 32'h80,       1));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        // FULL at four outstanding, then issue with a same-cycle completion
        tbl.push_back(mk(1,  0,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1,  0,  0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h2,        1));
        tbl.push_back(mk(1,  0,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h6,        2));
        tbl.push_back(mk(1,  0,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'hE,        3));
        tbl.push_back(mk(1,  0,  0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0,  1, 3, 0, 32'h1E,       4));
        tbl.push_back(mk(1,  0,  0, 0, 8, 1, 1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 32'h1E,       4));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h11C,      4));
        // RAW outranks WAW and FULL
        tbl.push_back(mk(1,  3,  0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h11C,      4));
        // drain
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,  0, 0, 0, 32'h11C,      4));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 32'h118,      3));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  0, 0, 0, 32'h110,      2));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0,  0, 0, 0, 32'h100,      1));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        // stray completion to a non-pending register must not wrap the count
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        // branch on an EX result via rs2: one-cycle stall, flush deferred
        tbl.push_back(mk(1,  3,  9, 1, 0, 0, 0, 1, 9, 1, 0, 0, 1,  1, 4, 0, 32'h0,        0));
        tbl.push_back(mk(1,  3,  9, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 32'h0,        0));
        // rs2 matches but is not read: no hazard
        tbl.push_back(mk(1,  3,  9, 0, 0, 0, 0, 1, 9, 1, 0, 0, 1,  0, 0, 1, 32'h0,        0));
        // load to x0 is never tracked
        tbl.push_back(mk(1,  0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1,  0,  0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0));

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_stall", {31'd0, pc_stall}, 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_outstanding", {29'd0, outstanding}, 32'd0);
        check("reset_wd_err", {31'd0, wd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            @(negedge clk);
            compare(i);
        end
        check("queue_drained", exp_q.size(), 32'd0);

        // Watchdog: 64 consecutive RAW stall cycles set wd_err after the 64th edge.
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1; id_rd = 5; id_reg_write = 1; id_is_load = 1;
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_rd = 6; id_reg_write = 1;
        @(negedge clk);
        check("wd_stall_on", {29'd0, stall_cause}, 32'd1);
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("wd_before_timeout", {31'd0, wd_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("wd_at_timeout", {31'd0, wd_err}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wd_sticky", {31'd0, wd_err}, 32'd1);

        // Asynchronous reset mid-stall, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stalls", {29'd0, pc_stall, if_id_stall, id_ex_bubble}, 32'd0);
        check("arst_cause", {29'd0, stall_cause}, 32'd0);
        check("arst_pending", pending, 32'd0);
        check("arst_outstanding", {29'd0, outstanding}, 32'd0);
        check("arst_wd_err", {31'd0, wd_err}, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
